// File: rtl/usb_fe_tx.sv
// rtl/usb_fe_tx.sv - USB full-speed transmit front end: SYNC, NRZI, bit stuffing, EOP and gap.
// Optional macro USB_FE_TX_LS_EN adds the ls_mode input for low-speed timing and polarity.
module usb_fe_tx #(
  parameter int CLK_PER_BIT = 4,
  parameter int IPD_BITS    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef USB_FE_TX_LS_EN
  input  logic       ls_mode,
`endif
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_err,
  output logic       busy,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       tx_oe
);

  localparam int CW = $clog2(8 * CLK_PER_BIT);
  localparam int NW = $clog2(IPD_BITS + 8);
  localparam logic [CW-1:0] FS_MAX  = CW'(CLK_PER_BIT - 1);
  localparam logic [NW-1:0] GAP_MAX = NW'(IPD_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J, S_GAP} state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_bit_cnt, w_bit_cnt_nx;
  logic [NW-1:0]   r_cnt, w_cnt_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic [3:0]      r_bits_left, w_bits_left_nx;
  logic [7:0]      r_hold, w_hold_nx;
  logic            r_hold_v, w_hold_v_nx;
  logic            r_last, w_last_nx;
  logic [2:0]      r_ones, w_ones_nx;
  logic            r_line, w_line_nx;
  logic            r_se0, w_se0_nx;
  logic            r_oe, w_oe_nx;
  logic            r_err, w_err_nx;
  logic            r_run;
  logic            w_ls;
  logic [CW-1:0]   w_bit_max;
  logic            w_bit_end;
  logic            w_accept;
  logic            w_hold_avail;
  logic [7:0]      w_hold_byte;
  logic            w_step;
  logic            w_bit;

`ifdef USB_FE_TX_LS_EN
  localparam logic [CW-1:0] LS_MAX = CW'(8 * CLK_PER_BIT - 1);
  logic r_ls;
  assign w_ls      = r_ls;
  assign w_bit_max = r_ls ? LS_MAX : FS_MAX;
`else
  assign w_ls      = 1'b0;
  assign w_bit_max = FS_MAX;
`endif

  assign w_bit_end = (r_bit_cnt == w_bit_max);
  assign tx_ready  = r_run & ((r_state == S_IDLE) |
                     (((r_state == S_SYNC) | (r_state == S_DATA)) & ~r_hold_v & ~r_last));
  assign w_accept  = tx_valid & tx_ready;
  // A byte accepted on the very boundary that needs it goes straight to the shifter.
  assign w_hold_avail = r_hold_v | w_accept;
  assign w_hold_byte  = r_hold_v ? r_hold : tx_data;
  assign w_step = w_bit_end & (((r_state == S_SYNC) & (r_cnt == NW'(7))) | (r_state == S_DATA));

  always_comb begin
    w_state_nx     = r_state;
    w_bit_cnt_nx   = (r_state == S_IDLE || w_bit_end) ? '0 : r_bit_cnt + 1'b1;
    w_cnt_nx       = r_cnt;
    w_shift_nx     = r_shift;
    w_bits_left_nx = r_bits_left;
    w_hold_nx      = r_hold;
    w_hold_v_nx    = r_hold_v;
    w_last_nx      = r_last;
    w_ones_nx      = r_ones;
    w_line_nx      = r_line;
    w_se0_nx       = r_se0;
    w_oe_nx        = r_oe;
    w_err_nx       = 1'b0;
    w_bit          = 1'b0;

    if (w_accept) begin
      w_hold_nx   = tx_data;
      w_hold_v_nx = 1'b1;
      w_last_nx   = tx_last;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nx     = S_SYNC;
          w_oe_nx        = 1'b1;
          w_line_nx      = 1'b0;
          w_se0_nx       = 1'b0;
          w_cnt_nx       = '0;
          w_ones_nx      = '0;
          w_bits_left_nx = '0;
        end
      end
      S_SYNC: begin
        // Sync bits 1..6 toggle; bit 7 holds K and starts the ones run at 1.
        if (w_bit_end && r_cnt != NW'(7)) begin
          w_cnt_nx  = r_cnt + 1'b1;
          w_line_nx = (r_cnt == NW'(6)) ? r_line : ~r_line;
          w_ones_nx = (r_cnt == NW'(6)) ? 3'd1 : 3'd0;
        end
      end
      S_EOP_SE0: begin
        if (w_bit_end) begin
          if (r_cnt == NW'(1)) begin
            w_state_nx = S_EOP_J;
            w_se0_nx   = 1'b0;
            w_line_nx  = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      S_EOP_J: begin
        if (w_bit_end) begin
          w_state_nx = S_GAP;
          w_oe_nx    = 1'b0;
          w_cnt_nx   = '0;
          w_last_nx  = 1'b0;
        end
      end
      S_GAP: begin
        if (w_bit_end) begin
          if (r_cnt == GAP_MAX) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (w_step) begin
      w_state_nx = S_DATA;
      if (r_ones == 3'd6) begin
        w_line_nx = ~r_line;
        w_ones_nx = '0;
      end else if (r_bits_left != 4'd0 || w_hold_avail) begin
        if (r_bits_left != 4'd0) begin
          w_bit          = r_shift[0];
          w_shift_nx     = r_shift >> 1;
          w_bits_left_nx = r_bits_left - 4'd1;
        end else begin
          w_bit          = w_hold_byte[0];
          w_shift_nx     = w_hold_byte >> 1;
          w_bits_left_nx = 4'd7;
          w_hold_v_nx    = 1'b0;
        end
        if (w_bit) begin
          w_ones_nx = r_ones + 3'd1;
        end else begin
          w_ones_nx = '0;
          w_line_nx = ~r_line;
        end
      end else begin
        w_state_nx = S_EOP_SE0;
        w_se0_nx   = 1'b1;
        w_cnt_nx   = '0;
        w_err_nx   = ~(r_last | (w_accept & tx_last));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_last      <= 1'b0;
      r_ones      <= '0;
      r_line      <= 1'b1;
      r_se0       <= 1'b0;
      r_oe        <= 1'b0;
      r_err       <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_cnt       <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_bits_left <= w_bits_left_nx;
      r_hold      <= w_hold_nx;
      r_hold_v    <= w_hold_v_nx;
      r_last      <= w_last_nx;
      r_ones      <= w_ones_nx;
      r_line      <= w_line_nx;
      r_se0       <= w_se0_nx;
      r_oe        <= w_oe_nx;
      r_err       <= w_err_nx;
      r_run       <= 1'b1;
    end
  end

`ifdef USB_FE_TX_LS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ls <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_ls <= ls_mode;
    end
  end
`endif

  // r_line is the J/K symbol (1 = J); low-speed swaps the pins, SE0 overrides both.
  assign dp_tx  = ~r_se0 & (r_line ^ w_ls);
  assign dn_tx  = ~r_se0 & ~(r_line ^ w_ls);
  assign tx_oe  = r_oe;
  assign tx_err = r_err;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_fe_tx.sv
// tb/tb_usb_fe_tx.sv - directed self-checking bench for usb_fe_tx (CLK_PER_BIT=4, IPD_BITS=6).
module tb_usb_fe_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ls_mode;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready, tx_err, busy, dp_tx, dn_tx, tx_oe;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  byte cap_q[$];
  int  err_cnt;
  int  err_at;

  localparam string A5_SYMS   = "KJKJKJKKKJJKJJKK00J";
  localparam string FF2_SYMS  = "KJKJKJKKKKKKKJJJJJJJKKKKKK00J";
  localparam string UNDR_SYMS = "KJKJKJKKKJJJKKJKJKJKJKJK00J";

  usb_fe_tx #(.CLK_PER_BIT(4), .IPD_BITS(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef USB_FE_TX_LS_EN
    .ls_mode  (ls_mode),
`endif
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .tx_err   (tx_err),
    .busy     (busy),
    .dp_tx    (dp_tx),
    .dn_tx    (dn_tx),
    .tx_oe    (tx_oe)
  );

  always #5 clk = ~clk;

  function automatic byte sym_now();
    if (!dp_tx && !dn_tx) return "0";
    if (dp_tx && !dn_tx)  return "J";
    if (!dp_tx && dn_tx)  return "K";
    return "X";
  endfunction

  always @(negedge clk) begin
    if (tx_err === 1'b1) begin
      err_cnt++;
      err_at = cap_q.size();
    end
    if (tx_oe === 1'b1) cap_q.push_back(sym_now());
  end

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string obs, input string exp);
    n_chk++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cap_q.delete();
    err_cnt = 0;
    err_at  = -1;
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit keep);
    int t = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    tx_last  = last;
    while (tx_ready !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk_int("send_accept_in_time", (t < 3000) ? 1 : 0, 1);
    @(negedge clk);
    if (!keep) begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      tx_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy === 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk_int("idle_in_time", (t < 5000) ? 1 : 0, 1);
  endtask

  task automatic decode(input int bc, output string s, output int bad);
    s = "";
    bad = 0;
    for (int i = 0; i + bc <= cap_q.size(); i += bc) begin
      byte c = cap_q[i];
      for (int j = 1; j < bc; j++) if (cap_q[i+j] != c) bad++;
      s = $sformatf("%s%c", s, c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    int    bad;
    int    n;
    int    t;

    rst_n = 1'b0; ls_mode = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk_int("rst_tx_oe",    int'(tx_oe),    0);
    chk_int("rst_dp",       int'(dp_tx),    1);
    chk_int("rst_dn",       int'(dn_tx),    0);
    chk_int("rst_busy",     int'(busy),     0);
    chk_int("rst_tx_ready", int'(tx_ready), 0);
    chk_int("rst_tx_err",   int'(tx_err),   0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_int("ready_after_reset", int'(tx_ready), 1);

    // single byte 0xA5 with tx_last
    clr();
    send(8'hA5, 1'b1, 1'b0);
    wait_idle();
    decode(4, s, bad);
    chk_int("a5_oe_clocks", cap_q.size(), 76);
    chk_str("a5_symbols", s, A5_SYMS);
    chk_int("a5_uneven_bits", bad, 0);
    chk_int("a5_err_pulses", err_cnt, 0);
    chk_int("a5_idle_dp", int'(dp_tx), 1);
    chk_int("a5_idle_dn", int'(dn_tx), 0);

    // 0xFF, 0xFF(last): two stuffed bits
    clr();
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    wait_idle();
    decode(4, s, bad);
    chk_int("ff2_oe_clocks", cap_q.size(), 116);
    chk_str("ff2_symbols", s, FF2_SYMS);
    chk_int("ff2_uneven_bits", bad, 0);
    chk_int("ff2_err_pulses", err_cnt, 0);

    // 0x2D, 0x00 without tx_last: underrun
    clr();
    send(8'h2D, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    wait_idle();
    decode(4, s, bad);
    chk_int("undr_oe_clocks", cap_q.size(), 108);
    chk_str("undr_symbols", s, UNDR_SYMS);
    chk_int("undr_err_pulses", err_cnt, 1);
    chk_int("undr_err_at_se0", err_at, 96);

    // tx_valid held high across packets
    clr();
    send(8'h3C, 1'b1, 1'b1);
    tx_data = 8'h81;
    tx_last = 1'b1;
    t = 0;
    while (tx_oe !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk_int("gap_oe_fell", (t < 2000) ? 1 : 0, 1);
    chk_int("gap_busy", int'(busy), 1);
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk_int("gap_ready_low_clocks", n, 24);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    chk_int("gap_next_oe", int'(tx_oe), 1);
    chk_int("gap_next_sync_dp", int'(dp_tx), 0);
    chk_int("gap_next_sync_dn", int'(dn_tx), 1);
    wait_idle();

    // reset pulse mid-DATA
    clr();
    send(8'hA5, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_int("midrst_tx_oe", int'(tx_oe),    0);
    chk_int("midrst_dp",    int'(dp_tx),    1);
    chk_int("midrst_dn",    int'(dn_tx),    0);
    chk_int("midrst_busy",  int'(busy),     0);
    chk_int("midrst_ready", int'(tx_ready), 0);
    @(negedge clk);
    chk_int("midrst_ready_after", int'(tx_ready), 1);
    clr();
    send(8'hA5, 1'b1, 1'b0);
    wait_idle();
    decode(4, s, bad);
    chk_int("midrst_oe_clocks", cap_q.size(), 76);
    chk_str("midrst_symbols", s, A5_SYMS);

`ifdef USB_FE_TX_LS_EN
    ls_mode = 1'b1;
    repeat (2) @(negedge clk);
    chk_int("ls_idle_dp", int'(dp_tx), 0);
    chk_int("ls_idle_dn", int'(dn_tx), 1);
    clr();
    send(8'hA5, 1'b1, 1'b0);
    wait_idle();
    decode(32, s, bad);
    chk_int("ls_oe_clocks", cap_q.size(), 608);
    chk_str("ls_symbols", s, "JKJKJKJJJKKJKKJJ00K");
    chk_int("ls_uneven_bits", bad, 0);
    ls_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
